alu_rr_scheduler: RTL
=====================

// Module: alu_rr_scheduler
// PURPOSE
//   Shares one multi-cycle ALU between N requesters. Round-robin arbitration
//   with valid/ready handshakes on both request and response sides. Sits
//   between the client ports and the ALU core.
//   FSM: accept request -> pulse ALU start -> wait for done -> return result.
//   A watchdog aborts an operation when the ALU never asserts done.
// PARAMETERS
//   N        4    number of requesters (2..8)
//   W        8    operand/result width in bits
//   OPW      4    ALU opcode width in bits
//   TIMEOUT  64   max cycles in WAIT before abort (>=2)
// PORTS
//   clk         in   1      system clock, all logic on rising edge
//   reset       in   1      synchronous, active-high reset
//   req_valid   in   N      per-requester request valid
//   req_ready   out  N      one-hot grant/accept, only in IDLE
//   req_op      in   N*OPW  opcodes, requester i at [i*OPW +: OPW]
//   req_a       in   N*W    operand A, requester i at [i*W +: W]
//   req_b       in   N*W    operand B, requester i at [i*W +: W]
//   alu_start   out  1      one-cycle start pulse to ALU
//   alu_op      out  OPW    latched opcode, stable from ISSUE to end of WAIT
//   alu_a       out  W      latched operand A, stable from ISSUE to end of WAIT
//   alu_b       out  W      latched operand B, stable from ISSUE to end of WAIT
//   alu_done    in   1      ALU result valid, one cycle; sampled only in WAIT
//   alu_result  in   W      ALU result, valid with alu_done
//   rsp_valid   out  1      response valid, held until rsp_ready
//   rsp_ready   in   1      consumer accepts response
//   rsp_id      out  clog2(N) index of the requester that owns the response
//   rsp_result  out  W      captured ALU result (0 on timeout)
//   rsp_err     out  1      1 = operation aborted by watchdog
// BEHAVIOUR
//   Reset (sync, high): state=IDLE, rr_ptr=0, wd_cnt=0.
//     All outputs 0: req_ready, alu_*, rsp_*.
//     Reset in any state drops the pending request and its result.
//     A late alu_done after reset is ignored.
//   IDLE
//     Winner = first i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... mod N.
//     req_ready = onehot(winner), driven combinationally in IDLE only.
//     req_ready = 0 when no req_valid bit is set.
//     On a grant: latch op/a/b and id=winner; next state ISSUE.
//   ISSUE
//     alu_start=1 for exactly one cycle; wd_cnt=0; next state WAIT.
//   WAIT
//     On alu_done: rsp_result<=alu_result, rsp_err<=0; next state RESP.
//     Else wd_cnt increments. When wd_cnt reaches TIMEOUT-1 with no done:
//       rsp_result<=0, rsp_err<=1; next state RESP.
//     A done on the same cycle as the timeout wins (err=0).
//   RESP
//     rsp_valid=1; rsp_id/result/err held stable until rsp_ready.
//     On rsp_valid&&rsp_ready: rr_ptr <= (id+1) mod N; next state IDLE.
//     No new grant in the handshake cycle.
//   Outside WAIT
//     alu_done is ignored.
//     req_valid is ignored outside IDLE; req_ready stays 0.
//   Latency
//     Grant in cycle t; alu_start in t+1.
//     ALU done in cycle d gives rsp_valid from d+1.
//     Minimum grant-to-response is 3 cycles (done in t+2).
//   Fairness
//     A continuously requesting client is granted within N transactions.
//   Invariants
//     At most one operation in flight.
//     rsp_valid never asserted during ISSUE or WAIT.
// TESTING
//   1 Reset: hold reset 2 cycles with req_valid=4'hF.
//     -> all outputs 0, state IDLE, no grant.
//   2 Single request: req_valid=4'b0100, op=ADD, a=8'h12, b=8'h34.
//     ALU returns done with 8'h46 two cycles after start.
//     -> req_ready=4'b0100; rsp_id=2, rsp_result=8'h46, rsp_err=0.
//   3 Round-robin: req_valid=4'hF held, rsp_ready=1.
//     -> grant order 0,1,2,3,0; rr_ptr wraps from 3 to 0.
//   4 Backpressure: rsp_ready=0 for 5 cycles after rsp_valid.
//     -> rsp fields stable, no new req_ready; grant follows the accept.
//   5 Timeout: TIMEOUT=8, ALU never asserts done.
//     -> rsp_err=1, rsp_result=0 after 8 WAIT cycles.
//     -> a stray alu_done in RESP or IDLE is ignored.
//   6 Reset mid-WAIT, then alu_done pulse.
//     -> IDLE, rsp_valid stays 0, next grant goes to requester 0 first.

Source files
------------

// File: rtl/alu_rr_scheduler.sv
// rtl/alu_rr_scheduler.sv - round-robin scheduler sharing one multi-cycle ALU among N requesters
module alu_rr_scheduler #(
    parameter int N       = 4,
    parameter int W       = 8,
    parameter int OPW     = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req_valid,
    output logic [N-1:0]         req_ready,
    input  logic [N*OPW-1:0]     req_op,
    input  logic [N*W-1:0]       req_a,
    input  logic [N*W-1:0]       req_b,
    output logic                 alu_start,
    output logic [OPW-1:0]       alu_op,
    output logic [W-1:0]         alu_a,
    output logic [W-1:0]         alu_b,
    input  logic                 alu_done,
    input  logic [W-1:0]         alu_result,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [$clog2(N)-1:0] rsp_id,
    output logic [W-1:0]         rsp_result,
    output logic                 rsp_err
);
    localparam int IDW = $clog2(N);
    localparam int WDW = $clog2(TIMEOUT);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
    localparam logic [IDW-1:0] ID_LAST = IDW'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t         state;
    state_t         state_n;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] cur_id;
    logic [WDW-1:0] wd_cnt;
    logic [IDW-1:0] scan_idx;
    logic [IDW-1:0] grant_idx;
    logic           grant_found;
    logic           wd_expired;

    // Scan downward so the requester closest to rr_ptr is the last (winning) assignment.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            scan_idx = IDW'((int'(rr_ptr) + k) % N);
            if (req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    assign wd_expired = (wd_cnt == WD_LAST);
    assign req_ready  = (!reset && state == ST_IDLE && grant_found) ? (N'(1) << grant_idx) : '0;
    assign alu_start  = (state == ST_ISSUE);
    assign rsp_valid  = (state == ST_RESP);
    assign rsp_id     = cur_id;

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:  if (grant_found) state_n = ST_ISSUE;
            ST_ISSUE: state_n = ST_WAIT;
            ST_WAIT:  if (alu_done || wd_expired) state_n = ST_RESP;
            ST_RESP:  if (rsp_ready) state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            rr_ptr     <= '0;
            cur_id     <= '0;
            wd_cnt     <= '0;
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                ST_IDLE: begin
                    if (grant_found) begin
                        cur_id <= grant_idx;
                        alu_op <= req_op[grant_idx*OPW +: OPW];
                        alu_a  <= req_a[grant_idx*W +: W];
                        alu_b  <= req_b[grant_idx*W +: W];
                    end
                end
                ST_ISSUE: wd_cnt <= '0;
                ST_WAIT: begin
                    // A done arriving on the expiry cycle still counts as success.
                    if (alu_done) begin
                        rsp_result <= alu_result;
                        rsp_err    <= 1'b0;
                    end else if (wd_expired) begin
                        rsp_result <= '0;
                        rsp_err    <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + WDW'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) rr_ptr <= (cur_id == ID_LAST) ? '0 : cur_id + IDW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule
